// File: rtl/hex_refresh_ctrl.sv
// rtl/hex_refresh_ctrl.sv - refresh scheduler time-sharing one 7-segment decoder across digits
// Optional digit blinking is compiled in with `define BLINK_EN.
module hex_refresh_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 50000,
    parameter int BLINK_PASSES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [2:0]              wr_addr,
    input  logic [3:0]              wr_data,
    input  logic                    wr_on,
    input  logic                    refresh_req,
`ifdef BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic                    dec_en,
    output logic [3:0]              dec_x,
    input  logic [6:0]              dec_y,
    output logic [7*NUM_DIGITS-1:0] hex_flat,
    output logic                    busy,
    output logic                    pass_done
);
    localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DEPTH = 1 << IW;
    localparam int PW    = $clog2(TICK_DIV);
    localparam logic [3:0]    ND_LIMIT = 4'(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
    state_t state, state_n;

    logic [PW-1:0]    presc;
    logic [IW-1:0]    idx;
    logic             pending;
    logic             tick;
    logic             trig;
    logic             wr_hit;
    logic             start;
    logic             blank_gate;
    logic [3:0]       val_r [DEPTH];
    logic [DEPTH-1:0] on_r;

    assign tick      = (presc == TICK_MAX);
    assign trig      = tick | refresh_req;
    assign wr_hit    = wr_en && ({1'b0, wr_addr} < ND_LIMIT);
    assign busy      = (state != IDLE);
    assign pass_done = (state == DONE);
    // A pass begins either from IDLE or chained directly off DONE; both consume pending.
    assign start     = (state_n == ISSUE) && ((state == IDLE) || (state == DONE));

`ifdef BLINK_EN
    localparam int BW = (BLINK_PASSES > 1) ? $clog2(BLINK_PASSES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PASSES - 1);

    logic [BW-1:0]    blink_cnt;
    logic             blink_phase;
    logic [DEPTH-1:0] mask_ext;

    assign mask_ext   = DEPTH'(blink_mask);
    assign blank_gate = blink_phase & mask_ext[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (pass_done) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign blank_gate = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (trig || pending) state_n = ISSUE;
            ISSUE:   state_n = CAPTURE;
            CAPTURE: state_n = (idx == LAST_IDX) ? DONE : ISSUE;
            DONE:    state_n = (trig || pending) ? ISSUE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            presc    <= '0;
            idx      <= '0;
            pending  <= 1'b0;
            dec_en   <= 1'b0;
            dec_x    <= '0;
            hex_flat <= '1;
            on_r     <= '0;
            for (int i = 0; i < DEPTH; i++) val_r[i] <= '0;
        end else begin
            state <= state_n;
            presc <= tick ? '0 : presc + 1'b1;

            if (start)
                pending <= 1'b0;
            else if (trig && busy)
                pending <= 1'b1;

            if (start)
                idx <= '0;
            else if (state == CAPTURE && state_n == ISSUE)
                idx <= idx + 1'b1;

            // Registered so the decoder settles during CAPTURE; reads pre-write storage.
            if (state == ISSUE) begin
                dec_x  <= val_r[idx];
                dec_en <= on_r[idx] & ~blank_gate;
            end else if (state == DONE) begin
                dec_en <= 1'b0;
            end

            if (state == CAPTURE) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    if (idx == IW'(i)) hex_flat[7*i +: 7] <= dec_y;
            end

            if (wr_hit) begin
                val_r[wr_addr[IW-1:0]] <= wr_data;
                on_r[wr_addr[IW-1:0]]  <= wr_on;
            end
        end
    end
endmodule

// File: doc/hex_refresh_ctrl.md
Name: hex_refresh_ctrl

Overview:
Scheduler that time-shares one combinational 7-segment hex decoder (4-bit value plus enable in, active-low 7-bit pattern out) among NUM_DIGITS display digits. It holds a per-digit value/enable register file written by the host. It periodically walks the digits: it drives the shared decoder, then captures the decoded pattern into per-digit output registers that feed the HEX pins directly. It sits between the host logic and the board's HEX outputs.

Parameters:
NUM_DIGITS, 4, number of digits sharing the decoder (1..8)
TICK_DIV, 50000, clocks per refresh tick (>=2)
BLINK_PASSES, 64, refresh passes per blink half-period (BLINK_EN only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  host write strobe, one cycle
wr_addr  in  3  digit index to write
wr_data  in  4  hex value to store
wr_on  in  1  digit enable to store (0 = blank)
refresh_req  in  1  forces a refresh pass without waiting for the tick
dec_en  out  1  to shared decoder enable
dec_x  out  4  to shared decoder value
dec_y  in  7  from shared decoder, active-low segments
hex_flat  out  7*NUM_DIGITS  digit i at bits [7i+6:7i], active-low
busy  out  1  refresh pass in progress
pass_done  out  1  one-cycle pulse at pass end

Behaviour:
- Reset (async, rst_n=0): all digit values = 0; all enables = 0; hex_flat all ones (blank); dec_en=0; dec_x=0; busy=0; pass_done=0; prescaler=0; pending=0; state IDLE. Releasing reset mid-pass discards the pass.
- Prescaler: counts 0..TICK_DIV-1 and wraps. A tick is asserted in the cycle the count equals TICK_DIV-1.
- Pass trigger: a tick, refresh_req, or pending in IDLE moves the FSM to ISSUE on the next edge with idx=0.
- Trigger while busy: sets pending, which saturates at one (multiple triggers are collapsed). When the pass completes, the FSM goes straight from DONE to ISSUE idx=0 and clears pending.
- FSM states: IDLE -> ISSUE -> CAPTURE -> (ISSUE idx+1 | DONE) -> IDLE.
- ISSUE: dec_x and dec_en are registered outputs loaded from entry idx, so they are valid during CAPTURE.
- CAPTURE: hex_flat[idx] <= dec_y at the end of the cycle. If idx == NUM_DIGITS-1, go to DONE; otherwise go to ISSUE with idx+1.
- DONE: pass_done=1 for exactly one cycle.
- Pass length: 2*NUM_DIGITS+1 cycles, from the first ISSUE through DONE.
- busy=1 in ISSUE, CAPTURE and DONE.
- dec_en=0 and dec_x hold their last value while in IDLE.
- Host writes: accepted in any state.
  - wr_addr >= NUM_DIGITS: write ignored.
  - A write to the digit being ISSUEd in the same cycle: the issue uses the old value; the new value appears on the next pass.
  - A write to a digit already captured in the current pass is shown on the next pass.
- hex_flat changes only in CAPTURE. The module never drives segments itself; the decoder output for dec_en=0 (all ones) yields blanking.

Optional Feature:
BLINK_EN
- With BLINK_EN: adds input blink_mask [NUM_DIGITS-1:0] and an internal blink_phase bit.
  - A pass counter counts pass_done pulses 0..BLINK_PASSES-1; blink_phase toggles on wrap.
  - In ISSUE, dec_en = enable[idx] & ~(blink_phase & blink_mask[idx]).
  - Reset values: blink_phase=0, counter=0.
- Without BLINK_EN: no blink_mask port, no counter; dec_en = enable[idx].

Test Plan:
1. Reset then idle (NUM_DIGITS=4, TICK_DIV=8): hex_flat=28'hFFFFFFF; first tick at cycle 7; busy rises at cycle 8; pass_done at cycle 16; hex_flat stays all ones because all digits are disabled.
2. Write digit0=4'h0/on, digit1=4'hA/on, digit3=4'hF/on, then refresh_req. After pass_done: digit0=7'b1000000, digit1=7'b0001000, digit2=7'b1111111, digit3=7'b0001110.
3. Write wr_addr=5 with wr_data=4'h8 and on: no state change; next pass hex_flat is unchanged.
4. During a pass, in the cycle ISSUE idx=2 is active, write digit2=4'h8 (old value 4'h3). This pass digit2=7'b0110000; next pass digit2=7'b0000000.
5. Assert refresh_req and take a tick during one pass: exactly one extra pass follows back-to-back (DONE then ISSUE, no IDLE), then the FSM returns to IDLE.
6. BLINK_EN, BLINK_PASSES=2, blink_mask=4'b0010, digit1=4'h5/on: digit1 reads 7'b0010010 for 2 passes, then 7'b1111111 for 2 passes, repeating; other digits are unaffected. Also assert rst_n low mid-pass: all outputs return to reset values immediately.
